// File: rtl/trigger_responder.sv
// rtl/trigger_responder.sv - trigger acceptance FSM with width qualification, dead time and saturating count
//
// Purpose: accepts an active-low trigger request once it has been low for
// MIN_CYC synchronized samples. After acceptance it holds a busy indication
// for DEAD_CYC cycles, and for as long afterwards as the request stays low.
// It also flags pulses that are too short and requests that arrive while busy.
//
// Ports:
//   sys_clk     in   single clock, rising edge
//   sys_rst_n   in   synchronous active-low reset
//   trig_in     in   active-low trigger request, asynchronous, idle high
//   trig_out    out  high while busy (BUSY or WAIT_REL), low when ready
//   acquire     out  one-cycle pulse on trigger acceptance
//   width_err   out  one-cycle pulse when the low pulse is shorter than MIN_CYC
//   retrig_err  out  one-cycle pulse when the request falls while busy
//   trig_count  out  accepted-trigger count, saturates at 16'hFFFF
module trigger_responder #(
  parameter int CLK_PER_US     = 12,
  parameter int T_US_MIN_WIDTH = 40,
  parameter int T_US_DEAD      = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        trig_in,
  output logic        trig_out,
  output logic        acquire,
  output logic        width_err,
  output logic        retrig_err,
  output logic [15:0] trig_count
);

  localparam int MIN_CYC  = T_US_MIN_WIDTH * CLK_PER_US;
  localparam int DEAD_CYC = T_US_DEAD * CLK_PER_US;
  localparam int LW       = $clog2(MIN_CYC) + 1;
  localparam int DW       = $clog2(DEAD_CYC) + 1;

  // The sample that completes MIN_CYC lows arrives while the counter holds MIN_CYC-1.
  localparam logic [LW-1:0] MIN_LAST  = LW'(MIN_CYC - 1);
  // Counting DEAD_CYC-1 down to 0 keeps the FSM in BUSY for exactly DEAD_CYC cycles.
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, BUSY, WAIT_REL} state_t;

  state_t        state, state_nxt;
  logic          sync1, trig_s, trig_s_d;
  logic [LW-1:0] low_cnt, low_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [15:0]   count_q, count_nxt;
  logic          acq_nxt, werr_nxt, rerr_nxt;
  logic          fall;

  // A new falling edge on the synchronized request, used only for busy-time detection.
  assign fall       = trig_s_d & ~trig_s;
  assign trig_out   = (state == BUSY) || (state == WAIT_REL);
  assign trig_count = count_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1      <= 1'b1;
      trig_s     <= 1'b1;
      trig_s_d   <= 1'b1;
      state      <= IDLE;
      low_cnt    <= '0;
      dead_cnt   <= '0;
      count_q    <= '0;
      acquire    <= 1'b0;
      width_err  <= 1'b0;
      retrig_err <= 1'b0;
    end else begin
      sync1      <= trig_in;
      trig_s     <= sync1;
      trig_s_d   <= trig_s;
      state      <= state_nxt;
      low_cnt    <= low_nxt;
      dead_cnt   <= dead_nxt;
      count_q    <= count_nxt;
      acquire    <= acq_nxt;
      width_err  <= werr_nxt;
      retrig_err <= rerr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    low_nxt   = low_cnt;
    dead_nxt  = dead_cnt;
    count_nxt = count_q;
    acq_nxt   = 1'b0;
    werr_nxt  = 1'b0;
    rerr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!trig_s) begin
          state_nxt = MEASURE;
          low_nxt   = LW'(1);
        end
      end
      MEASURE: begin
        if (trig_s) begin
          werr_nxt  = 1'b1;
          state_nxt = IDLE;
          low_nxt   = '0;
        end else if (low_cnt == MIN_LAST) begin
          state_nxt = BUSY;
          low_nxt   = '0;
          acq_nxt   = 1'b1;
          dead_nxt  = DEAD_LOAD;
          if (count_q != 16'hFFFF) count_nxt = count_q + 16'd1;
        end else begin
          low_nxt = low_cnt + LW'(1);
        end
      end
      BUSY: begin
        rerr_nxt = fall;
        if (dead_cnt == '0) begin
          // A request still held low must be released before the next one counts.
          state_nxt = trig_s ? IDLE : WAIT_REL;
        end else begin
          dead_nxt = dead_cnt - DW'(1);
        end
      end
      WAIT_REL: begin
        rerr_nxt = fall;
        if (trig_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trigger_responder.sv
// tb/tb_trigger_responder.sv - directed self-checking bench for trigger_responder
module tb_trigger_responder;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        trig_in;
  logic        trig_out, acquire, width_err, retrig_err;
  logic [15:0] trig_count;

  int n_checks = 0;
  int n_fail   = 0;

  int acq_n, acq_at, werr_n, werr_at, rerr_n, rerr_at, to_n, to_first, to_last, dbl, excl;
  logic [15:0] exp_cnt;

  trigger_responder #(.CLK_PER_US(1), .T_US_MIN_WIDTH(4), .T_US_DEAD(10)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .trig_in(trig_in), .trig_out(trig_out),
    .acquire(acquire), .width_err(width_err), .retrig_err(retrig_err), .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  function automatic logic pin_level(input int j, input int len0, input int s1, input int len1);
    return !((j < len0) || (j >= s1 && j < s1 + len1));
  endfunction

  // Edge k (index 0) is the first edge that samples the pin at the first window level.
  task automatic run(input int len0, input int s1, input int len1, input int rst_at, input int ncyc);
    logic pa, pw, pr;
    acq_n = 0; acq_at = -1; werr_n = 0; werr_at = -1; rerr_n = 0; rerr_at = -1;
    to_n = 0; to_first = -1; to_last = -1; dbl = 0; excl = 0;
    pa = 1'b0; pw = 1'b0; pr = 1'b0;
    trig_in = pin_level(0, len0, s1, len1);
    sys_rst_n = (rst_at == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (acquire)    begin acq_n++;  if (acq_at < 0)  acq_at = i;  end
      if (width_err)  begin werr_n++; if (werr_at < 0) werr_at = i; end
      if (retrig_err) begin rerr_n++; if (rerr_at < 0) rerr_at = i; end
      if (trig_out)   begin to_n++; if (to_first < 0) to_first = i; to_last = i; end
      if ((acquire && pa) || (width_err && pw) || (retrig_err && pr)) dbl++;
      if (acquire && width_err) excl++;
      pa = acquire; pw = width_err; pr = retrig_err;
      trig_in = pin_level(i + 1, len0, s1, len1);
      sys_rst_n = (i + 1 == rst_at) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0; trig_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL reset_trig_out got %b want 0", trig_out); end
    n_checks++; if ({acquire, width_err, retrig_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {acquire, width_err, retrig_err}); end
    n_checks++; if (trig_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h want 0000", trig_count); end
    sys_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_cnt = 16'h0000;
  endtask

  task automatic test_basic;
    run(6, -1, 0, -1, 25);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (acq_n !== 1 || acq_at !== 5) begin n_fail++; $display("FAIL basic_acquire got n=%0d at=%0d want n=1 at=5", acq_n, acq_at); end
    n_checks++; if (to_n !== 10 || to_first !== 5 || to_last !== 14) begin n_fail++; $display("FAIL basic_trig_out got n=%0d %0d..%0d want 10 5..14", to_n, to_first, to_last); end
    n_checks++; if (werr_n !== 0 || rerr_n !== 0) begin n_fail++; $display("FAIL basic_errors got w=%0d r=%0d want 0 0", werr_n, rerr_n); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL basic_count got %h want %h", trig_count, exp_cnt); end
    n_checks++; if (dbl !== 0 || excl !== 0) begin n_fail++; $display("FAIL basic_pulse_shape got dbl=%0d excl=%0d want 0 0", dbl, excl); end
  endtask

  task automatic test_width;
    run(3, -1, 0, -1, 12);
    n_checks++; if (werr_n !== 1 || werr_at !== 5) begin n_fail++; $display("FAIL short_width_err got n=%0d at=%0d want n=1 at=5", werr_n, werr_at); end
    n_checks++; if (to_n !== 0 || acq_n !== 0) begin n_fail++; $display("FAIL short_no_accept got to=%0d acq=%0d want 0 0", to_n, acq_n); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL short_count got %h want %h", trig_count, exp_cnt); end
    run(4, -1, 0, -1, 25);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (acq_n !== 1 || acq_at !== 5 || werr_n !== 0) begin n_fail++; $display("FAIL min_accept got acq=%0d at=%0d werr=%0d want 1 5 0", acq_n, acq_at, werr_n); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL min_count got %h want %h", trig_count, exp_cnt); end
  endtask

  task automatic test_long;
    run(30, -1, 0, -1, 40);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (acq_n !== 1) begin n_fail++; $display("FAIL long_acq_n got %0d want 1", acq_n); end
    n_checks++; if (to_first !== 5 || to_last !== 31 || to_n !== 27) begin n_fail++; $display("FAIL long_trig_out got n=%0d %0d..%0d want 27 5..31", to_n, to_first, to_last); end
    n_checks++; if (werr_n !== 0 || rerr_n !== 0) begin n_fail++; $display("FAIL long_errors got w=%0d r=%0d want 0 0", werr_n, rerr_n); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL long_count got %h want %h", trig_count, exp_cnt); end
  endtask

  task automatic test_retrig;
    run(6, 7, 2, -1, 25);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (rerr_n !== 1 || rerr_at !== 9) begin n_fail++; $display("FAIL retrig_err got n=%0d at=%0d want n=1 at=9", rerr_n, rerr_at); end
    n_checks++; if (to_n !== 10 || to_first !== 5 || to_last !== 14) begin n_fail++; $display("FAIL retrig_trig_out got n=%0d %0d..%0d want 10 5..14", to_n, to_first, to_last); end
    n_checks++; if (acq_n !== 1 || werr_n !== 0) begin n_fail++; $display("FAIL retrig_acq got acq=%0d werr=%0d want 1 0", acq_n, werr_n); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL retrig_count got %h want %h", trig_count, exp_cnt); end
  endtask

  task automatic test_reset_busy;
    run(6, -1, 0, 10, 20);
    exp_cnt = 16'h0000;
    n_checks++; if (to_n !== 5 || to_first !== 5 || to_last !== 9) begin n_fail++; $display("FAIL rst_busy_trig_out got n=%0d %0d..%0d want 5 5..9", to_n, to_first, to_last); end
    n_checks++; if (werr_n !== 0 || rerr_n !== 0) begin n_fail++; $display("FAIL rst_busy_errors got w=%0d r=%0d want 0 0", werr_n, rerr_n); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL rst_busy_count got %h want %h", trig_count, exp_cnt); end
  endtask

  task automatic test_reset_measure;
    run(30, -1, 0, 3, 45);
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (werr_n !== 0 || rerr_n !== 0) begin n_fail++; $display("FAIL rst_meas_errors got w=%0d r=%0d want 0 0", werr_n, rerr_n); end
    n_checks++; if (acq_n !== 1 || acq_at !== 9) begin n_fail++; $display("FAIL rst_meas_acquire got n=%0d at=%0d want n=1 at=9", acq_n, acq_at); end
    n_checks++; if (to_first !== 9 || to_last !== 31) begin n_fail++; $display("FAIL rst_meas_trig_out got %0d..%0d want 9..31", to_first, to_last); end
    n_checks++; if (trig_count !== exp_cnt) begin n_fail++; $display("FAIL rst_meas_count got %h want %h", trig_count, exp_cnt); end
  endtask

  task automatic test_saturation;
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    run(6, -1, 0, -1, 25);
    n_checks++; if (acq_n !== 1 || trig_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got acq=%0d cnt=%h want 1 ffff", acq_n, trig_count); end
    run(6, -1, 0, -1, 25);
    n_checks++; if (acq_n !== 1 || acq_at !== 5) begin n_fail++; $display("FAIL sat_acquire got n=%0d at=%0d want n=1 at=5", acq_n, acq_at); end
    n_checks++; if (trig_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", trig_count); end
  endtask

  initial begin
    exp_cnt = 16'h0000;
    test_reset;
    test_basic;
    test_width;
    test_long;
    test_retrig;
    test_reset_busy;
    test_reset_measure;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
